// File: rtl/seq_divider_unsigned.sv
// ---------------------------------------------------------------------------
// seq_divider_unsigned
//
// Iterative unsigned restoring divider. Produces one quotient bit per clock,
// MSB first, and sits beside the combinational array multiplier in the
// arithmetic datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (overrides everything)
//   start        request; only looked at while idle
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while the iterative loop is running
//   done         one-cycle pulse; quotient/remainder/div_by_zero are valid
//   quotient     registered quotient (held until the next result)
//   remainder    registered remainder (held until the next result)
//   div_by_zero  registered flag: the captured divisor was zero
//   dbg_state    current FSM state (0=IDLE, 1=RUN, 2=FINISH)
//
// Handshake: start is a request that is accepted on any rising edge where
// the FSM is in IDLE and start=1; in every other state start is ignored.
// After acceptance busy stays high for WIDTH cycles (never for a zero
// divisor), then done pulses for exactly one cycle together with valid
// results. There is no back-pressure on done: the result simply holds on
// quotient/remainder/div_by_zero until the next accepted start overwrites it.
// ---------------------------------------------------------------------------
module seq_divider_unsigned #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_sr;   // dividend, shifted out MSB first
    logic [WIDTH-1:0] dvs;      // captured divisor
    logic [WIDTH:0]   prem;     // partial remainder
    logic [WIDTH-1:0] quo_sr;   // quotient bits collected so far

    // One restoring step. The shifted remainder is widened by one more bit
    // so that the top bit of the trial difference is a clean borrow flag.
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH:0]   next_prem;
    logic [WIDTH-1:0] next_quo;

    always_comb begin
        trial     = {prem, dvd_sr[WIDTH-1]} - {2'b00, dvs};
        fits      = ~trial[WIDTH+1];
        next_prem = fits ? trial[WIDTH:0] : {prem[WIDTH-1:0], dvd_sr[WIDTH-1]};
        next_quo  = {quo_sr[WIDTH-2:0], fits};
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_sr      <= '0;
            dvs         <= '0;
            prem        <= '0;
            quo_sr      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        dvd_sr      <= dividend;
                        dvs         <= divisor;
                        prem        <= '0;
                        quo_sr      <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor: skip the loop and report the
                            // conventional all-ones quotient right away.
                            state       <= FINISH;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end

                RUN: begin
                    prem   <= next_prem;
                    quo_sr <= next_quo;
                    dvd_sr <= {dvd_sr[WIDTH-2:0], 1'b0};
                    if (cnt == '0) begin
                        // Last step: publish the step's outputs directly so
                        // the result is valid in the FINISH cycle.
                        state     <= FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= next_quo;
                        remainder <= next_prem[WIDTH-1:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_unsigned.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_unsigned
//
// Two instances: WIDTH=4 for directed cases and the exhaustive sweep,
// WIDTH=8 for random operands. The reference model is plain arithmetic
// (a / b, a % b) plus the documented latency: a request presented in cycle
// dc is accepted at the following edge, busy covers the next WIDTH cycles
// and done appears WIDTH+1 cycles after dc (1 cycle for a zero divisor).
// ---------------------------------------------------------------------------
module tb_seq_divider_unsigned;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, dbz4;
    logic       busy8, done8, dbz8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic [1:0] st4, st8;

    seq_divider_unsigned #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4),
        .div_by_zero(dbz4), .dbg_state(st4)
    );

    seq_divider_unsigned #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div_by_zero(dbz8), .dbg_state(st8)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        int          id;    // 0 = WIDTH 4 instance, 1 = WIDTH 8 instance
        int          dc;    // cycle in which start was presented
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_q[2];
    logic [31:0] last_r[2];
    logic        last_dbz[2];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (d == 1) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = s; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   w;
        w     = (d == 1) ? 8 : 4;
        e.id  = d;
        e.dc  = cyc;
        e.a   = a;
        e.b   = b;
        e.dbz = (b == 0);
        e.q   = (b == 0) ? ((32'd1 << w) - 32'd1) : a / b;
        e.r   = (b == 0) ? a : a % b;
        exp_q.push_back(e);
    endtask

    // Present a request, then hold start high with other operands (ma, mb)
    // until the earliest cycle in which a new request could be accepted.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ma, input logic [31:0] mb);
        int w;
        w = (d == 1) ? 8 : 4;
        drive(d, 1'b1, a, b);
        push_exp(d, a, b);
        tick(1);
        drive(d, 1'b1, ma, mb);
        tick((b != 0) ? w + 1 : 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                int          w;
                logic        have, acc, eb, ed;
                exp_t        e;
                logic [31:0] oq, orr;
                logic        ob, od, oz;
                string       s;
                w    = (d == 1) ? 8 : 4;
                s    = (d == 1) ? "8" : "4";
                oq   = (d == 1) ? {24'd0, q8} : {28'd0, q4};
                orr  = (d == 1) ? {24'd0, r8} : {28'd0, r4};
                ob   = (d == 1) ? busy8 : busy4;
                od   = (d == 1) ? done8 : done4;
                oz   = (d == 1) ? dbz8 : dbz4;
                have = (exp_q.size() > 0) && (exp_q[0].id == d);
                acc  = 1'b0;
                eb   = 1'b0;
                ed   = 1'b0;
                if (have) begin
                    e   = exp_q[0];
                    acc = (cyc > e.dc);
                    eb  = acc && (e.b != 0) && (cyc <= e.dc + w);
                    ed  = acc && (cyc == e.dc + 1 + ((e.b != 0) ? w : 0));
                end
                if (ed) begin
                    last_q[d]   = e.q;
                    last_r[d]   = e.r;
                    last_dbz[d] = e.dbz;
                    void'(exp_q.pop_front());
                end else if (acc && e.b != 0) begin
                    last_dbz[d] = 1'b0;
                end
                check({"busy", s}, ob, eb);
                check({"done", s}, od, ed);
                check({"quotient", s}, oq, last_q[d]);
                check({"remainder", s}, orr, last_r[d]);
                check({"div_by_zero", s}, oz, last_dbz[d]);
                if (ed && e.b != 0) begin
                    check({"invariant", s}, oq * e.b + orr, e.a);
                    check({"rem_lt_div", s}, (orr < e.b) ? 32'd1 : 32'd0, 32'd1);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            for (int d = 0; d < 2; d++) begin
                last_q[d]   = '0;
                last_r[d]   = '0;
                last_dbz[d] = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            last_q[d]   = '0;
            last_r[d]   = '0;
            last_dbz[d] = 1'b0;
        end
        rst = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        tick(3);
        rst = 1'b0;
        tick(1);
        mon_en = 1;

        // Reset values
        check("reset_busy4", busy4, 0);
        check("reset_done4", done4, 0);
        check("reset_quotient4", q4, 0);
        check("reset_remainder4", r4, 0);
        check("reset_dbz8", dbz8, 0);

        // Directed cases, WIDTH 4
        issue(0, 13, 3, 13, 3);   drive(0, 1'b0, 0, 0); tick(2);
        issue(0, 3, 9, 3, 9);     drive(0, 1'b0, 0, 0); tick(2);
        issue(0, 15, 1, 15, 1);   drive(0, 1'b0, 0, 0); tick(2);
        issue(0, 15, 15, 15, 15); drive(0, 1'b0, 0, 0); tick(2);
        issue(0, 7, 0, 7, 0);
        issue(0, 8, 2, 8, 2);     drive(0, 1'b0, 0, 0); tick(3);

        // start held with 9/3 through RUN and FINISH must be ignored
        issue(0, 12, 5, 9, 3);    drive(0, 1'b0, 0, 0); tick(3);

        // Reset in the middle of a division discards it
        drive(0, 1'b1, 14, 4);
        push_exp(0, 14, 4);
        tick(1);
        drive(0, 1'b0, 14, 4);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_busy4", busy4, 0);
        check("midrst_done4", done4, 0);
        check("midrst_quotient4", q4, 0);
        check("midrst_remainder4", r4, 0);
        tick(20);
        issue(0, 14, 4, 14, 4);   drive(0, 1'b0, 0, 0); tick(3);

        // Exhaustive sweep, start held high, operands scrambled mid-run
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(0, a, b, $urandom_range(0, 15), $urandom_range(0, 15));
            end
        end
        drive(0, 1'b0, 0, 0);
        tick(3);

        // Random operands, WIDTH 8 (small divisors and zero favoured sometimes)
        repeat (1000) begin
            logic [31:0] ra, rb;
            ra = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 3);
                default: rb = $urandom_range(0, 255);
            endcase
            issue(1, ra, rb, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        drive(1, 1'b0, 0, 0);
        tick(4);

        check("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider_unsigned.md
Name: seq_divider_unsigned

Overview:
- Iterative unsigned restoring divider; the inverse of the team's combinational array multiplier.
- Computes quotient and remainder of dividend/divisor, one quotient bit per clock, MSB first.
- Sits beside the multiplier in the arithmetic datapath.
- Handshake is start/busy/done, so a controller can issue one division at a time.

Parameters:
- WIDTH, 4, operand width in bits. Quotient and remainder are also WIDTH bits. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: results are valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag; set when the captured divisor is 0

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high, evaluated on the rising edge, and overrides all other inputs.
- Reset values: state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - busy=0.
  - If start=1 at an edge, capture dividend and divisor, clear the partial remainder (WIDTH+1 bits), and clear div_by_zero.
  - If the captured divisor != 0: go to RUN with counter=WIDTH-1.
  - If the captured divisor == 0: go directly to FINISH. Set quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN (exactly WIDTH cycles), each cycle:
  - Shift the partial remainder left by 1, bringing in the current MSB of the dividend shift register.
  - Trial-subtract the divisor.
  - If the result is non-negative: keep the difference and shift in quotient bit 1. Otherwise: restore and shift in 0.
  - When counter==0, go to FINISH; otherwise decrement counter. busy=1 throughout.
- FINISH (one cycle):
  - done=1 and busy=0. quotient and remainder are valid.
  - Unconditionally go to IDLE next cycle. start is ignored in FINISH.
- Results hold after done. quotient, remainder and div_by_zero hold their values until the next accepted start.
  - On an accepted start, quotient and remainder are not cleared until they are overwritten.
- Latency:
  - Start accepted at edge k: busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
  - Divide-by-zero: done=1 in cycle k+1 and busy never asserts.
  - Throughput: one division per WIDTH+2 cycles.
- start while busy or in FINISH: ignored, with no effect on the running operation or its outputs. Operand changes after capture have no effect.
- Width rules:
  - All arithmetic is unsigned.
  - The partial remainder is WIDTH+1 bits internally, so the trial subtract cannot overflow.
  - Outputs are truncated to WIDTH; the final remainder is always < divisor.
- Invariant (non-zero divisor): quotient*divisor + remainder == dividend. No X on any output after reset.
- Reset mid-operation: any state returns to IDLE next edge, with all outputs at reset values. A pending result is discarded and no done is produced.

Test Plan:
- Reset, then start with dividend=13, divisor=3 (WIDTH=4) -> busy high 4 cycles; done pulses at cycle k+5; quotient=4, remainder=1, div_by_zero=0.
- dividend=3, divisor=9 -> quotient=0, remainder=3. Also dividend=15, divisor=1 -> quotient=15, remainder=0. Also dividend=15, divisor=15 -> quotient=1, remainder=0.
- dividend=7, divisor=0 -> done at k+1, busy never high; quotient=15, remainder=7, div_by_zero=1. A following 8/2 -> quotient=4, remainder=0, div_by_zero=0.
- Start 12/5, then pulse start with 9/3 during RUN and during FINISH -> both ignored. Exactly one done; quotient=2, remainder=2.
- Start 14/4, assert rst at cycle k+2 -> next cycle busy=0, done=0, quotient=0, remainder=0. No done appears later. A new start 14/4 completes with quotient=3, remainder=2.
- Exhaustive sweep of all 256 operand pairs back to back (WIDTH=4), plus 1000 random pairs at WIDTH=8 -> quotient*divisor + remainder == dividend for divisor != 0. done spacing is exactly WIDTH+2 cycles when start is held high.
